// File: rtl/cc_result_uart_tx.sv
// 8N1 UART transmitter for the three cross-correlation lag results.
// Sends SYNC_BYTE, Lag_0, Lag_1, Lag_2, XOR checksum on a rising edge of TX_en.
module cc_result_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TX_en,
    input  logic [7:0] Lag_0,
    input  logic [7:0] Lag_1,
    input  logic [7:0] Lag_2,
    output logic       RsTx,
    output logic       Tx_Ready,
    output logic       Tx_Busy
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [2:0]       byte_idx, byte_next;
    logic             tx_en_q;
    logic [4:0][7:0]  shadow;
    logic             start;
    logic             bit_end;
    logic [7:0]       cur_byte;
    logic             rs_tx_d;
    logic             ready_d;
    logic             busy_d;

    assign start   = (state == IDLE) && TX_en && !tx_en_q;
    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_en_q  <= 1'b1;
            shadow   <= '0;
            RsTx     <= 1'b1;
            Tx_Ready <= 1'b0;
            Tx_Busy  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_next;
            byte_idx <= byte_next;
            tx_en_q  <= TX_en;
            if (start) begin
                shadow <= {Lag_0 ^ Lag_1 ^ Lag_2, Lag_2, Lag_1, Lag_0, SYNC_BYTE};
            end
            RsTx     <= rs_tx_d;
            Tx_Ready <= ready_d;
            Tx_Busy  <= busy_d;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        case (state)
            IDLE: begin
                cnt_next  = '0;
                bit_next  = '0;
                byte_next = '0;
                if (start) state_next = START;
            end
            START: begin
                cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    if (byte_idx == 3'd4) begin
                        state_next = DONE;
                    end else begin
                        state_next = START;
                        byte_next  = byte_idx + 3'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they describe, with no path from inputs to pins.
    always_comb begin
        cur_byte = '1;
        case (byte_next)
            3'd0:    cur_byte = shadow[0];
            3'd1:    cur_byte = shadow[1];
            3'd2:    cur_byte = shadow[2];
            3'd3:    cur_byte = shadow[3];
            3'd4:    cur_byte = shadow[4];
            default: cur_byte = '1;
        endcase
        rs_tx_d = 1'b1;
        case (state_next)
            START:   rs_tx_d = 1'b0;
            DATA:    rs_tx_d = cur_byte[bit_next];
            default: rs_tx_d = 1'b1;
        endcase
        busy_d  = (state_next == START) || (state_next == DATA) || (state_next == STOP);
        ready_d = (state_next == DONE);
    end

endmodule
